// File: rtl/seq_pattern_loader_pkg.sv
// seq_pattern_loader_pkg: shared frame constants and FSM state types
package seq_pattern_loader_pkg;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int NUM_ROWS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {HUNT, ROWS, CSUM, COMMIT} fr_state_t;
endpackage

// File: rtl/seq_pattern_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver; clk, rst (async low), rxd raw line in; data byte, valid and ferr one-cycle pulses out
module uart_rx_byte
  import seq_pattern_loader_pkg::*;
#(
  parameter int DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID = CW'(DIV / 2 - 1);
  rx_state_t st, st_n;
  logic s1, s2, s3, valid_n, ferr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s3, s2, s1} <= 3'b111;
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      valid <= 1'b0;
      ferr <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rxd};
      st <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
      data <= sh_n;
      valid <= valid_n;
      ferr <= ferr_n;
    end
  always_comb begin
    st_n = st;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (st)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        st_n = s3 & ~s2 ? START : IDLE;
      end
      START: if (cnt == MID) begin
        cnt_n = '0;
        st_n = s2 ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {s2, data[7:1]};
        idx_n = idx + 1'b1;
        st_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        st_n = IDLE;
        valid_n = s2;
        ferr_n = ~s2;
      end
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: rtl/seq_pattern_loader.sv
// seq_pattern_loader: UART frame (A5, 8 rows, xor) to 8x8 grid writes; clk, rst (async low), rxd in; wr_en/wr_addr/wr_data, busy, frame_ok, frame_err out
module seq_pattern_loader
  import seq_pattern_loader_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD = 115200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int TO = TIMEOUT_BITS * DIV;
  localparam int GW = $clog2(TO + 1);
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
  fr_state_t fst, fst_n;
  logic [7:0] data, csum, csum_n, pend_d, hd;
  logic [7:0] rows [NUM_ROWS];
  logic [2:0] row, row_n;
  logic [GW-1:0] gap, gap_n;
  logic valid, ferr, pend, pend_n, ok_n, err_n, hv, abort;
  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .data(data),
    .valid(valid),
    .ferr(ferr)
  );
  // a byte finishing during COMMIT is held and judged once back in HUNT
  assign hv = valid | pend;
  assign hd = pend ? pend_d : data;
  assign abort = ferr | (gap == GW'(TO - 1));
  assign wr_en = fst == COMMIT;
  assign wr_addr = wr_en ? row : '0;
  assign wr_data = wr_en ? rows[row] : '0;
  assign busy = fst != HUNT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fst <= HUNT;
      row <= '0;
      csum <= '0;
      gap <= '0;
      pend <= 1'b0;
      pend_d <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) rows[i] <= '0;
    end else begin
      fst <= fst_n;
      row <= row_n;
      csum <= csum_n;
      gap <= gap_n;
      pend <= pend_n;
      frame_ok <= ok_n;
      frame_err <= err_n;
      if (fst == ROWS && valid) rows[row] <= data;
      if (wr_en && valid) pend_d <= data;
    end
  always_comb begin
    fst_n = fst;
    row_n = row;
    csum_n = csum;
    gap_n = gap + 1'b1;
    pend_n = pend | (wr_en & valid);
    ok_n = 1'b0;
    err_n = 1'b0;
    case (fst)
      HUNT: begin
        row_n = '0;
        csum_n = '0;
        gap_n = '0;
        pend_n = 1'b0;
        fst_n = hv && hd == HDR_BYTE ? ROWS : HUNT;
      end
      ROWS: if (valid) begin
        gap_n = '0;
        csum_n = csum ^ data;
        row_n = row + 1'b1;
        fst_n = row == LAST_ROW ? CSUM : ROWS;
      end else if (abort) begin
        err_n = 1'b1;
        fst_n = HUNT;
      end
      CSUM: if (valid) begin
        fst_n = data == csum ? COMMIT : HUNT;
        err_n = data != csum;
      end else if (abort) begin
        err_n = 1'b1;
        fst_n = HUNT;
      end
      COMMIT: begin
        row_n = row + 1'b1;
        fst_n = row == LAST_ROW ? HUNT : COMMIT;
        ok_n = row == LAST_ROW;
      end
      default: fst_n = HUNT;
    endcase
  end
endmodule

// File: doc/seq_pattern_loader.md
SEQ_PATTERN_LOADER -- requirements
Module: seq_pattern_loader

Interface
REQ-001 Parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter TIMEOUT_BITS, default 16, maximum idle gap between bytes within a frame, in bit periods.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rxd  input  1  asynchronous UART receive line, idle high, 8N1, LSB first.
REQ-007 wr_en  output  1  grid write strobe for the 8x8 step pattern store.
REQ-008 wr_addr  output  3  row (step) index being written.
REQ-009 wr_data  output  8  row bitmap; bit k set = note k enabled.
REQ-010 busy  output  1  high while a frame is in progress or being committed.
REQ-011 frame_ok  output  1  one-cycle pulse: a frame was committed.
REQ-012 frame_err  output  1  one-cycle pulse: a frame was aborted.

Function
REQ-013 rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Bit period DIV SHALL equal CLK_HZ/BAUD, integer-truncated (234 at defaults); the half period SHALL be DIV/2 (117).
REQ-015 Byte receiver states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a synchronised falling edge; START samples rxd at half period; rxd=1 at that sample -> IDLE (glitch rejected, no byte).
REQ-017 DATA SHALL sample 8 bits at full-period intervals from the start-bit centre, LSB first.
REQ-018 STOP samples one period after bit 7; rxd=1 -> byte valid for one cycle; rxd=0 -> framing error; either way -> IDLE.
REQ-019 Frame format: header 0xA5, then 8 row bytes (row 0 first), then checksum byte equal to the XOR of the 8 row bytes.
REQ-020 Frame states: HUNT, ROWS, CSUM, COMMIT.
REQ-021 HUNT: valid byte 0xA5 -> ROWS with row index 0; any other byte or framing error is ignored silently.
REQ-022 ROWS: each valid byte is stored in an internal 8x8 buffer at the row index; after row 7 -> CSUM.
REQ-023 CSUM: checksum match -> COMMIT; mismatch -> frame_err pulse, HUNT.
REQ-024 Framing error in ROWS or CSUM -> frame_err pulse, HUNT, buffer contents discarded.
REQ-025 Gap counter in ROWS/CSUM: no completed byte within TIMEOUT_BITS*DIV cycles after the previous one -> frame_err pulse, HUNT.
REQ-026 COMMIT: wr_en high for exactly 8 consecutive cycles, wr_addr 0..7, wr_data equal to buffer row; frame_ok pulses in the cycle after the last write; -> HUNT.
REQ-027 No partial frame SHALL ever produce wr_en.
REQ-028 The byte receiver SHALL keep running during COMMIT; a byte completing during COMMIT (impossible at defaults, 8 cycles << 1 byte) is evaluated in HUNT after COMMIT ends.
REQ-029 A 0xA5 received as row or checksum data SHALL be treated as data, not as a resync.
REQ-030 busy high in ROWS, CSUM and COMMIT; low in HUNT.
REQ-031 wr_addr and wr_data SHALL be 0 whenever wr_en is low.

Reset
REQ-032 Reset asserted SHALL force IDLE, HUNT, all counters 0, buffer 0, and all outputs 0 within the same cycle, asynchronously.
REQ-033 Reset asserted mid-frame or mid-commit SHALL abandon the frame; the remaining writes SHALL not occur and frame_ok/frame_err SHALL not pulse.
REQ-034 Synchroniser flops SHALL reset to 1 (idle line).

Structure
REQ-035 A shared package SHALL hold the constants HDR_BYTE=8'hA5 and NUM_ROWS=8, and the state enums for both FSMs.
REQ-036 The byte receiver SHALL be one sub-module, uart_rx_byte (outputs: data[7:0], valid, ferr); the frame FSM, buffer and commit logic SHALL be in the top module.

Verification
REQ-037 Frame A5 01 02 04 08 10 20 40 80 FF -> 8 writes (addr 0..7, data 01..80), then frame_ok=1 for one cycle.
REQ-038 Same frame with checksum 00 -> frame_err pulse, no wr_en at any point.
REQ-039 Bytes 3C 00 then frame A5 FF x8 00 -> first two bytes ignored; 8 writes of FF; frame_ok.
REQ-040 Frame stopped after the 4th row byte, line idle for 17 bit periods -> frame_err pulse at 16*234 cycles after the 4th byte; next full frame commits.
REQ-041 rxd low pulse of 50 cycles on an idle line -> no byte, no state change; stop bit forced 0 on row 2 -> frame_err pulse.
REQ-042 Reset asserted on the 3rd commit cycle -> wr_en low immediately, no frame_ok; busy=0 after reset release.
